dbg_run_ctrl: RTL and testbench
===============================

// Module: dbg_run_ctrl
// PURPOSE
//  Per-core run-control for the debug subsystem: NUM_CORES independent RUN/HALT/STEP FSMs driving per-core clock enables.
//  Adds multi-cycle stepping (step_count), per-core targeting, breakpoint auto-halt and configurable halt-on-reset.
//  Sits in the sys_clk domain behind the cdc_sync_stb strobes from the TAP; downstream negedge gate latches form dbg_clk.
// PARAMETERS
//  NUM_CORES      1  number of independently gated cores (1..8)
//  STEP_W         8  width of step_count; max step = 2**STEP_W-1 cycles
//  HALT_ON_RESET  0  1: every core enters HALT on reset; 0: RUN
// PORTS
//  sys_clk      in   1          system clock; all state on posedge
//  reset        in   1          synchronous, active-high reset
//  core_sel     in   NUM_CORES  target mask for halt/step/resume strobes
//  halt_req     in   1          1-cycle strobe: halt selected cores
//  step_req     in   1          1-cycle strobe: step selected halted cores
//  resume_req   in   1          1-cycle strobe: resume selected halted cores
//  step_count   in   STEP_W     cycles per step; sampled with step_req
//  bp_hit       in   NUM_CORES  level breakpoint match per core
//  clk_en       out  NUM_CORES  registered clock enable per core
//  halted       out  NUM_CORES  1 = core in HALT
//  bp_cause     out  NUM_CORES  sticky: halt caused by bp_hit
//  step_done    out  NUM_CORES  1-cycle pulse on STEP->HALT completion
// BEHAVIOUR
//  Reset (sync, high): state=HALT_ON_RESET?HALT:RUN; clk_en=~halted; bp_cause=0; step_done=0; counters=0.
//  All inputs sampled on posedge sys_clk; every output registered; 1-cycle latency from strobe to clk_en/halted.
//  Per-core FSM (core i acts only if core_sel[i]=1, except bp_hit which is per-core unconditional):
//   RUN : halt_req -> HALT, clk_en=0. bp_hit[i] -> HALT, clk_en=0, bp_cause[i]=1. step/resume ignored.
//   HALT: step_req & step_count!=0 -> STEP, clk_en=1, cnt=step_count-1.
//         step_req & step_count==0 -> no-op (stay HALT, no step_done).
//         resume_req -> RUN, clk_en=1, bp_cause[i]=0. halt_req/bp_hit ignored.
//   STEP: cnt==0 -> HALT, clk_en=0, step_done[i]=1 for one cycle; else cnt-=1, clk_en stays 1.
//         halt_req -> abort: HALT, clk_en=0, no step_done. bp_hit and step/resume ignored in STEP.
//  Net effect: step of N keeps clk_en high for exactly N consecutive cycles.
//  Simultaneous strobes same cycle, precedence: halt_req > step_req > resume_req.
//  bp_hit and halt_req together in RUN: HALT with bp_cause=1.
//  core_sel==0: all strobes are no-ops; bp_hit still acts.
//  Reset mid-STEP: counter cleared, no step_done, state per HALT_ON_RESET.
//  step_count is not re-read during STEP; changing it mid-step has no effect.
//  Cores are fully independent; no cross-core state.
// TESTING
//  T1 reset, HALT_ON_RESET=0 -> clk_en=all 1, halted=0, bp_cause=0, step_done=0.
//  T2 core_sel=1, halt_req; then step_req step_count=3 -> clk_en[0] high 3 cycles, step_done[0] pulses once, halted[0]=1.
//  T3 halted, step_req step_count=0 -> no change, no step_done; resume_req -> clk_en=1 next cycle.
//  T4 RUN, bp_hit[1]=1 (NUM_CORES=2, core_sel=0) -> halted=2'b10, bp_cause[1]=1; resume core 1 -> bp_cause[1]=0.
//  T5 step of 10, halt_req at cycle 4 -> clk_en low next cycle, no step_done; halt+step+resume same cycle in HALT -> stays HALT.
//  T6 reset asserted mid-STEP with HALT_ON_RESET=1 -> next cycle halted=all 1, clk_en=0, no step_done.

Source files
------------

// File: rtl/dbg_run_ctrl_if.sv
// Run-control bundle between the TAP-side strobe source and dbg_run_ctrl.
// The master drives strobes and breakpoints; the slave returns per-core gating status.
interface dbg_run_ctrl_if #(
  parameter int NUM_CORES = 1,
  parameter int STEP_W    = 8
);
  logic [NUM_CORES-1:0] core_sel;
  logic                 halt_req;
  logic                 step_req;
  logic                 resume_req;
  logic [STEP_W-1:0]    step_count;
  logic [NUM_CORES-1:0] bp_hit;
  logic [NUM_CORES-1:0] clk_en;
  logic [NUM_CORES-1:0] halted;
  logic [NUM_CORES-1:0] bp_cause;
  logic [NUM_CORES-1:0] step_done;

  modport master (
    output core_sel, halt_req, step_req, resume_req, step_count, bp_hit,
    input  clk_en, halted, bp_cause, step_done
  );

  modport slave (
    input  core_sel, halt_req, step_req, resume_req, step_count, bp_hit,
    output clk_en, halted, bp_cause, step_done
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Per-core RUN/HALT/STEP run control producing registered clock enables for the
// downstream gate latches, with multi-cycle stepping and breakpoint auto-halt.
module dbg_run_ctrl #(
  parameter int NUM_CORES     = 1,
  parameter int STEP_W        = 8,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input logic           sys_clk,
  input logic           reset,
  dbg_run_ctrl_if.slave dbg
);
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam state_t RST_STATE = HALT_ON_RESET ? ST_HALT : ST_RUN;

  logic [NUM_CORES-1:0] w_clk_en;
  logic [NUM_CORES-1:0] w_halted;
  logic [NUM_CORES-1:0] w_bp_cause;
  logic [NUM_CORES-1:0] w_step_done;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      state_t            r_state;
      logic [STEP_W-1:0] r_cnt;
      logic              r_clk_en;
      logic              r_halted;
      logic              r_bp_cause;
      logic              r_step_done;
      logic              w_halt;
      logic              w_step;
      logic              w_resume;

      assign w_halt   = dbg.core_sel[gi] & dbg.halt_req;
      assign w_step   = dbg.core_sel[gi] & dbg.step_req;
      assign w_resume = dbg.core_sel[gi] & dbg.resume_req;

      always_ff @(posedge sys_clk) begin
        if (reset) begin
          r_state     <= RST_STATE;
          r_cnt       <= '0;
          r_clk_en    <= ~HALT_ON_RESET;
          r_halted    <= HALT_ON_RESET;
          r_bp_cause  <= 1'b0;
          r_step_done <= 1'b0;
        end else begin
          r_step_done <= 1'b0;
          case (r_state)
            ST_RUN: begin
              if (dbg.bp_hit[gi] || w_halt) begin
                r_state    <= ST_HALT;
                r_clk_en   <= 1'b0;
                r_halted   <= 1'b1;
                r_bp_cause <= dbg.bp_hit[gi];
              end
            end
            ST_HALT: begin
              // A halt strobe outranks step/resume even though it is a no-op here.
              if (!w_halt) begin
                if (w_step) begin
                  if (dbg.step_count != '0) begin
                    r_state  <= ST_STEP;
                    r_cnt    <= dbg.step_count - STEP_W'(1);
                    r_clk_en <= 1'b1;
                    r_halted <= 1'b0;
                  end
                end else if (w_resume) begin
                  r_state    <= ST_RUN;
                  r_clk_en   <= 1'b1;
                  r_halted   <= 1'b0;
                  r_bp_cause <= 1'b0;
                end
              end
            end
            ST_STEP: begin
              if (w_halt) begin
                r_state  <= ST_HALT;
                r_clk_en <= 1'b0;
                r_halted <= 1'b1;
                r_cnt    <= '0;
              end else if (r_cnt == '0) begin
                r_state     <= ST_HALT;
                r_clk_en    <= 1'b0;
                r_halted    <= 1'b1;
                r_step_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt - STEP_W'(1);
              end
            end
            default: begin
              r_state  <= RST_STATE;
              r_cnt    <= '0;
              r_clk_en <= ~HALT_ON_RESET;
              r_halted <= HALT_ON_RESET;
            end
          endcase
        end
      end

      assign w_clk_en[gi]    = r_clk_en;
      assign w_halted[gi]    = r_halted;
      assign w_bp_cause[gi]  = r_bp_cause;
      assign w_step_done[gi] = r_step_done;
    end
  endgenerate

  assign dbg.clk_en    = w_clk_en;
  assign dbg.halted    = w_halted;
  assign dbg.bp_cause  = w_bp_cause;
  assign dbg.step_done = w_step_done;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Drives two dbg_run_ctrl instances (run-on-reset and halt-on-reset) with shared
// directed and random stimulus, comparing every output each cycle to a cycle-budget model.
module tb_dbg_run_ctrl;
  localparam int NC = 3;
  localparam int SW = 8;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic clk;
  logic rst;

  dbg_run_ctrl_if #(.NUM_CORES(NC), .STEP_W(SW)) if0 ();
  dbg_run_ctrl_if #(.NUM_CORES(NC), .STEP_W(SW)) if1 ();

  dbg_run_ctrl #(.NUM_CORES(NC), .STEP_W(SW), .HALT_ON_RESET(1'b0)) u_dut0 (
    .sys_clk(clk),
    .reset  (rst),
    .dbg    (if0.slave)
  );

  dbg_run_ctrl #(.NUM_CORES(NC), .STEP_W(SW), .HALT_ON_RESET(1'b1)) u_dut1 (
    .sys_clk(clk),
    .reset  (rst),
    .dbg    (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode per core and number of enabled cycles still owed to a step.
  int mode   [2][NC];
  int budget [2][NC];
  bit bpc    [2][NC];
  bit done   [2][NC];

  bit track = 1'b0;
  int en_seen = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_update(input bit r, input logic [NC-1:0] sel, input bit h,
                              input bit s, input bit rs, input int cnt,
                              input logic [NC-1:0] bp);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        done[d][c] = 1'b0;
        if (r) begin
          mode[d][c]   = (d == 1) ? M_HALT : M_RUN;
          budget[d][c] = 0;
          bpc[d][c]    = 1'b0;
        end else if (mode[d][c] == M_RUN) begin
          if (bp[c]) begin
            mode[d][c] = M_HALT;
            bpc[d][c]  = 1'b1;
          end else if (h && sel[c]) begin
            mode[d][c] = M_HALT;
          end
        end else if (mode[d][c] == M_HALT) begin
          if (sel[c] && !h) begin
            if (s) begin
              if (cnt > 0) begin
                mode[d][c]   = M_STEP;
                budget[d][c] = cnt;
              end
            end else if (rs) begin
              mode[d][c] = M_RUN;
              bpc[d][c]  = 1'b0;
            end
          end
        end else begin
          if (sel[c] && h) begin
            mode[d][c]   = M_HALT;
            budget[d][c] = 0;
          end else begin
            budget[d][c] = budget[d][c] - 1;
            if (budget[d][c] == 0) begin
              mode[d][c] = M_HALT;
              done[d][c] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0] e_en, e_hl, e_bc, e_sd;
    logic [NC-1:0] o_en, o_hl, o_bc, o_sd;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        e_en[c] = (mode[d][c] != M_HALT);
        e_hl[c] = (mode[d][c] == M_HALT);
        e_bc[c] = bpc[d][c];
        e_sd[c] = done[d][c];
      end
      if (d == 0) begin
        o_en = if0.clk_en; o_hl = if0.halted; o_bc = if0.bp_cause; o_sd = if0.step_done;
      end else begin
        o_en = if1.clk_en; o_hl = if1.halted; o_bc = if1.bp_cause; o_sd = if1.step_done;
      end
      chk($sformatf("dut%0d clk_en t=%0t", d, $time), 32'(o_en), 32'(e_en));
      chk($sformatf("dut%0d halted t=%0t", d, $time), 32'(o_hl), 32'(e_hl));
      chk($sformatf("dut%0d bp_cause t=%0t", d, $time), 32'(o_bc), 32'(e_bc));
      chk($sformatf("dut%0d step_done t=%0t", d, $time), 32'(o_sd), 32'(e_sd));
    end
  endtask

  task automatic cycle(input bit r, input logic [NC-1:0] sel, input bit h, input bit s,
                       input bit rs, input int cnt, input logic [NC-1:0] bp);
    rst = r;
    if0.core_sel = sel; if0.halt_req = h; if0.step_req = s; if0.resume_req = rs;
    if0.step_count = SW'(cnt); if0.bp_hit = bp;
    if1.core_sel = sel; if1.halt_req = h; if1.step_req = s; if1.resume_req = rs;
    if1.step_count = SW'(cnt); if1.bp_hit = bp;
    @(posedge clk);
    model_update(r, sel, h, s, rs, cnt, bp);
    #1;
    compare_all();
    if (track) begin
      en_seen   += int'(if0.clk_en[0]);
      done_seen += int'(if0.step_done[0]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    cycle(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, '0);
    cycle(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, '0);
    // T1
    chk("t1_clk_en", 32'(if0.clk_en), 32'(3'b111));
    chk("t1_halted", 32'(if0.halted), 32'(3'b000));
    idle(2);

    // T2: halt core 0, step 3
    cycle(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 0, '0);
    chk("t2_halted", 32'(if0.halted), 32'(3'b001));
    track = 1'b1; en_seen = 0; done_seen = 0;
    cycle(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 3, '0);
    idle(5);
    track = 1'b0;
    chk("t2_en_cycles", 32'(en_seen), 32'd3);
    chk("t2_done_pulses", 32'(done_seen), 32'd1);

    // T3: zero-length step, then resume
    cycle(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 0, '0);
    chk("t3_zero_step", 32'(if0.halted[0]), 32'd1);
    cycle(1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 0, '0);
    chk("t3_resume", 32'(if0.clk_en[0]), 32'd1);

    // T4: breakpoint with no selection, then resume core 1
    cycle(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 3'b010);
    chk("t4_halted", 32'(if0.halted), 32'(3'b010));
    chk("t4_bp_cause", 32'(if0.bp_cause), 32'(3'b010));
    cycle(1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 0, '0);
    chk("t4_bp_clear", 32'(if0.bp_cause), 32'(3'b000));

    // T5: step of 10 aborted by halt, then all strobes together while halted
    cycle(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 0, '0);
    track = 1'b1; en_seen = 0; done_seen = 0;
    cycle(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 10, '0);
    idle(3);
    cycle(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 0, '0);
    chk("t5_abort_en", 32'(if0.clk_en[0]), 32'd0);
    idle(12);
    track = 1'b0;
    chk("t5_abort_cycles", 32'(en_seen), 32'd4);
    chk("t5_no_done", 32'(done_seen), 32'd0);
    cycle(1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 5, '0);
    chk("t5_all_strobes", 32'(if0.halted[0]), 32'd1);

    // T6: reset mid-step on the halt-on-reset instance
    cycle(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 20, '0);
    idle(3);
    cycle(1'b1, '0, 1'b0, 1'b0, 1'b0, 0, '0);
    chk("t6_halted", 32'(if1.halted), 32'(3'b111));
    chk("t6_clk_en", 32'(if1.clk_en), 32'(3'b000));
    chk("t6_step_done", 32'(if1.step_done), 32'(3'b000));

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, h, s, rs;
      int cnt;
      logic [NC-1:0] sel, bp;
      r   = ($urandom_range(0, 199) == 0);
      sel = NC'($urandom);
      h   = ($urandom_range(0, 9) == 0);
      s   = ($urandom_range(0, 5) == 0);
      rs  = ($urandom_range(0, 5) == 0);
      cnt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      bp  = '0;
      for (int c = 0; c < NC; c++) bp[c] = ($urandom_range(0, 24) == 0);
      cycle(r, sel, h, s, rs, cnt, bp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
